gate_g: RTL and testbench

GATE_G -- requirements
Module: gate_g

---
 rtl/gate_g.sv | 81 ++++++++
 tb/tb_gate_g.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/gate_g.sv
// ---------------------------------------------------------------------------
// gate_g -- clock-enabled D register with capture status outputs.
//
// Captures d into q on a rising clk edge when enable is high. Alongside the
// data it reports whether anything has been captured since reset (q_valid)
// and a one-cycle pulse following each capture edge (load).
//
// Parameters
//   WIDTH    data path width in bits (1..64)
//   RST_VAL  value forced onto q while reset is asserted
//
// Ports (positional order is d, clk, enable, q, rst_n, q_valid, load; the
// first four match the original 4-port register so old positional
// instances still bind the same way)
//   d        in   WIDTH  data to capture
//   clk      in   1      sole clock, rising edge
//   enable   in   1      capture enable, active-high
//   q        out  WIDTH  registered data
//   rst_n    in   1      asynchronous active-low reset
//   q_valid  out  1      at least one capture since reset
//   load     out  1      high for the cycle after each capture edge
// ---------------------------------------------------------------------------
module gate_g #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             enable,
  output logic [WIDTH-1:0] q,
  input  logic             rst_n,
  output logic             q_valid,
  output logic             load
);

  // Reset release is absorbed by one flop: the first rising edge after
  // rst_n goes high only arms the block, so the earliest capture is the
  // second edge. Captures can therefore never race the reset release.
  logic armed_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_reg <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
    end
  end

  // Capture qualifier. An unknown enable makes this unknown, and the
  // if/else below then falls to the hold branch, so X/Z is never taken
  // as a capture.
  logic capture;
  assign capture = armed_reg & enable;

  logic [WIDTH-1:0] q_reg;
  logic             q_valid_reg;
  logic             load_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= RST_VAL;
      q_valid_reg <= 1'b0;
      load_reg    <= 1'b0;
    end else begin
      if (capture) begin
        // A capture of a value equal to q still counts as a capture.
        q_reg       <= d;
        q_valid_reg <= 1'b1;
        load_reg    <= 1'b1;
      end else begin
        load_reg    <= 1'b0;
      end
    end
  end

  // Outputs come straight from flops; nothing combinational from d/enable.
  assign q       = q_reg;
  assign q_valid = q_valid_reg;
  assign load    = load_reg;

endmodule

// File: tb/tb_gate_g.sv
// ---------------------------------------------------------------------------
// tb_gate_g -- directed self-checking bench for gate_g.
// Instance a: default WIDTH=1, RST_VAL=0. Instance b: WIDTH=8, RST_VAL=8'hA5.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_gate_g;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a
  logic       a_d, a_enable, a_rst_n;
  logic       a_q, a_q_valid, a_load;
  // instance b
  logic [7:0] b_d;
  logic       b_enable, b_rst_n;
  logic [7:0] b_q;
  logic       b_q_valid, b_load;

  gate_g u_a (
    .d(a_d), .clk(clk), .enable(a_enable), .q(a_q),
    .rst_n(a_rst_n), .q_valid(a_q_valid), .load(a_load)
  );

  gate_g #(.WIDTH(8), .RST_VAL(8'hA5)) u_b (
    .d(b_d), .clk(clk), .enable(b_enable), .q(b_q),
    .rst_n(b_rst_n), .q_valid(b_q_valid), .load(b_load)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic eq, input logic ev, input logic el);
    check({tag, ".q"},       64'(a_q),       64'(eq));
    check({tag, ".q_valid"}, 64'(a_q_valid), 64'(ev));
    check({tag, ".load"},    64'(a_load),    64'(el));
  endtask

  initial begin
    a_d = 1'b0; a_enable = 1'b0; a_rst_n = 1'b0;
    b_d = 8'h00; b_enable = 1'b0; b_rst_n = 1'b0;
    tick(); tick();
    check_a("reset", 1'b0, 1'b0, 1'b0);

    // edges ignored while in reset
    a_enable = 1'b1; a_d = 1'b1;
    tick();
    check_a("rst_edge_ignored", 1'b0, 1'b0, 1'b0);

    // release mid-cycle; first edge after release only arms
    a_rst_n = 1'b1;
    tick();
    check_a("arm_edge", 1'b0, 1'b0, 1'b0);

    // second edge captures d=1
    tick();
    check_a("cap1", 1'b1, 1'b1, 1'b1);
    a_enable = 1'b0;
    tick();
    check_a("cap1_after", 1'b1, 1'b1, 1'b0);

    // capture 0 over 1
    a_enable = 1'b1; a_d = 1'b0;
    tick();
    check_a("cap0", 1'b0, 1'b1, 1'b1);

    // hold while d toggles
    a_enable = 1'b0; a_d = 1'b1;
    tick();
    check_a("hold1", 1'b0, 1'b1, 1'b0);
    a_d = 1'b0;
    tick();
    check_a("hold2", 1'b0, 1'b1, 1'b0);
    a_d = 1'b1;
    tick();
    check_a("hold3", 1'b0, 1'b1, 1'b0);

    // glitch between edges has no effect
    a_d = 1'b1; a_enable = 1'b1;
    #2;
    a_d = 1'b0; a_enable = 1'b0;
    tick();
    check_a("glitch", 1'b0, 1'b1, 1'b0);

    // capture of value equal to q still pulses load
    a_enable = 1'b1; a_d = 1'b0;
    tick();
    check_a("cap_same", 1'b0, 1'b1, 1'b1);

    // back-to-back capture keeps load high
    a_d = 1'b1;
    tick();
    check_a("b2b", 1'b1, 1'b1, 1'b1);

    // async reset mid-cycle, checked well before the next edge
    a_rst_n = 1'b0;
    #1;
    check_a("async_rst", 1'b0, 1'b0, 1'b0);
    tick();
    check_a("rst_hold1", 1'b0, 1'b0, 1'b0);
    tick();
    check_a("rst_hold2", 1'b0, 1'b0, 1'b0);

    // WIDTH=8, RST_VAL=A5
    check("b.reset.q",       64'(b_q),       64'h A5);
    check("b.reset.q_valid", 64'(b_q_valid), 64'h0);
    b_rst_n = 1'b1;
    tick();
    check("b.arm.q", 64'(b_q), 64'h A5);
    b_enable = 1'b1; b_d = 8'h3C;
    tick();
    check("b.cap.q",       64'(b_q),       64'h3C);
    check("b.cap.q_valid", 64'(b_q_valid), 64'h1);
    check("b.cap.load",    64'(b_load),    64'h1);
    b_enable = 1'b0; b_d = 8'hFF;
    tick();
    check("b.hold.q",    64'(b_q),    64'h3C);
    check("b.hold.load", 64'(b_load), 64'h0);
    b_rst_n = 1'b0;
    #1;
    check("b.async_rst.q", 64'(b_q), 64'h A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
